// File: rtl/mips32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips32_pkg
// Description : Opcodes, instruction classes, ALU operations and pipeline
//               register layouts shared by the mips32 pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package mips32_pkg;

    localparam logic [5:0] c_OP_ADD   = 6'b000000;
    localparam logic [5:0] c_OP_SUB   = 6'b000001;
    localparam logic [5:0] c_OP_AND   = 6'b000010;
    localparam logic [5:0] c_OP_OR    = 6'b000011;
    localparam logic [5:0] c_OP_SLT   = 6'b000100;
    localparam logic [5:0] c_OP_MUL   = 6'b000101;
    localparam logic [5:0] c_OP_LW    = 6'b001000;
    localparam logic [5:0] c_OP_SW    = 6'b001001;
    localparam logic [5:0] c_OP_ADDI  = 6'b001010;
    localparam logic [5:0] c_OP_SUBI  = 6'b001011;
    localparam logic [5:0] c_OP_SLTI  = 6'b001100;
    localparam logic [5:0] c_OP_BNEQZ = 6'b001101;
    localparam logic [5:0] c_OP_BEQZ  = 6'b001110;
    localparam logic [5:0] c_OP_HLT   = 6'b111111;

    // Opcode 111110 is unassigned, so this word decodes as a bubble.
    localparam logic [31:0] c_NOP_IR = 32'hF800_0000;

    typedef enum logic [2:0] {
        CLS_NOP    = 3'd0,
        CLS_RR_ALU = 3'd1,
        CLS_RM_ALU = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_BRANCH = 3'd5,
        CLS_HALT   = 3'd6
    } instr_class_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_MUL = 3'd5
    } alu_op_e;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] npc;
    } if_id_t;

    typedef struct packed {
        instr_class_e cls;
        alu_op_e      op;
        logic         br_on_zero;
        logic [4:0]   rs;
        logic [4:0]   rt;
        logic [4:0]   dest;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [31:0]  imm;
        logic [31:0]  npc;
    } id_ex_t;

    typedef struct packed {
        instr_class_e cls;
        logic [4:0]   dest;
        logic [31:0]  alu_out;
        logic [31:0]  b;
        logic         taken;
        logic [31:0]  target;
    } ex_mem_t;

    typedef struct packed {
        instr_class_e cls;
        logic [4:0]   dest;
        logic [31:0]  alu_out;
        logic [31:0]  lmd;
    } mem_wb_t;

    localparam if_id_t c_IF_ID_NOP = '{ir: c_NOP_IR, npc: 32'd0};
    localparam id_ex_t c_ID_EX_NOP = '{cls: CLS_NOP, op: ALU_ADD, br_on_zero: 1'b0,
                                       rs: 5'd0, rt: 5'd0, dest: 5'd0,
                                       a: 32'd0, b: 32'd0, imm: 32'd0, npc: 32'd0};
    localparam ex_mem_t c_EX_MEM_NOP = '{cls: CLS_NOP, dest: 5'd0, alu_out: 32'd0,
                                         b: 32'd0, taken: 1'b0, target: 32'd0};
    localparam mem_wb_t c_MEM_WB_NOP = '{cls: CLS_NOP, dest: 5'd0, alu_out: 32'd0,
                                         lmd: 32'd0};

    function automatic instr_class_e f_classify(input logic [5:0] op);
        instr_class_e cls;
        case (op)
            c_OP_ADD, c_OP_SUB, c_OP_AND,
            c_OP_OR, c_OP_SLT, c_OP_MUL:     cls = CLS_RR_ALU;
            c_OP_ADDI, c_OP_SUBI, c_OP_SLTI: cls = CLS_RM_ALU;
            c_OP_LW:                         cls = CLS_LOAD;
            c_OP_SW:                         cls = CLS_STORE;
            c_OP_BNEQZ, c_OP_BEQZ:           cls = CLS_BRANCH;
            c_OP_HLT:                        cls = CLS_HALT;
            default:                         cls = CLS_NOP;
        endcase
        return cls;
    endfunction

    // Loads and stores reuse the adder for rs + imm.
    function automatic alu_op_e f_alu_op(input logic [5:0] op);
        alu_op_e aop;
        case (op)
            c_OP_SUB, c_OP_SUBI: aop = ALU_SUB;
            c_OP_AND:            aop = ALU_AND;
            c_OP_OR:             aop = ALU_OR;
            c_OP_SLT, c_OP_SLTI: aop = ALU_SLT;
            c_OP_MUL:            aop = ALU_MUL;
            default:             aop = ALU_ADD;
        endcase
        return aop;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips32_alu.sv
`default_nettype none
// ============================================================================
// Module      : mips32_alu
// Description : Combinational integer ALU for the mips32 pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module mips32_alu
    import mips32_pkg::*;
(
    input  alu_op_e     i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result
);

    // Select the operation; SLT compares as signed, MUL keeps the low word.
    always_comb begin
        o_result = 32'd0;
        case (i_op)
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_SLT: o_result = {31'd0, ($signed(i_a) < $signed(i_b))};
            ALU_MUL: o_result = i_a * i_b;
            default: o_result = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pipe_mips32.sv
`default_nettype none
// ============================================================================
// Module      : pipe_mips32
// Description : 5-stage in-order MIPS32-subset core with unified word memory,
//               write-first register file, forwarding, load-use stall,
//               branch squash in MEM and HLT freeze.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_mips32
    import mips32_pkg::*;
#(
    parameter int MEM_WORDS = 1024
)(
    input  logic clk,
    input  logic rst,
    output logic halted
);

    localparam int c_AW = $clog2(MEM_WORDS);

    // Architectural state; Mem and Reg are deliberately left out of reset.
    logic [31:0] Mem [0:MEM_WORDS-1];
    logic [31:0] Reg [0:31];
    logic [31:0] PC;
    logic        HALTED;
    logic        TAKEN_BRANCH;

    if_id_t  r_if_id;
    id_ex_t  r_id_ex;
    ex_mem_t r_ex_mem;
    mem_wb_t r_mem_wb;

    if_id_t      w_if_id_nx;
    id_ex_t      w_id_ex_nx;
    ex_mem_t     w_ex_mem_nx;
    mem_wb_t     w_mem_wb_nx;
    logic [31:0] w_pc_nx;

    logic [5:0]   w_op;
    logic [4:0]   w_rs, w_rt, w_rd, w_dest;
    instr_class_e w_cls;
    logic [31:0]  w_rs_val, w_rt_val;
    logic         w_uses_rs, w_uses_rt;
    logic         w_wb_we;
    logic [31:0]  w_wb_data;
    logic         w_exm_fwd;
    logic [31:0]  w_fwd_a, w_fwd_b, w_alu_b, w_alu_out;
    logic         w_taken;
    logic         w_squash, w_stall, w_fetch_stop;
    logic [c_AW-1:0] w_mem_addr;

    assign halted = HALTED;

    // ---------------- ID decode ----------------
    assign w_op  = r_if_id.ir[31:26];
    assign w_rs  = r_if_id.ir[25:21];
    assign w_rt  = r_if_id.ir[20:16];
    assign w_rd  = r_if_id.ir[15:11];
    assign w_cls = f_classify(w_op);

    assign w_uses_rs = (w_cls == CLS_RR_ALU) || (w_cls == CLS_RM_ALU) || (w_cls == CLS_LOAD) ||
                       (w_cls == CLS_STORE) || (w_cls == CLS_BRANCH);
    assign w_uses_rt = (w_cls == CLS_RR_ALU) || (w_cls == CLS_STORE);

    // Write-back port, also used as the same-cycle bypass into ID.
    assign w_wb_we   = ((r_mem_wb.cls == CLS_RR_ALU) || (r_mem_wb.cls == CLS_RM_ALU) ||
                        (r_mem_wb.cls == CLS_LOAD)) && (r_mem_wb.dest != 5'd0);
    assign w_wb_data = (r_mem_wb.cls == CLS_LOAD) ? r_mem_wb.lmd : r_mem_wb.alu_out;

    // Register read with R0 hardwired to zero and the WB value visible first.
    always_comb begin
        w_rs_val = Reg[w_rs];
        w_rt_val = Reg[w_rt];
        if (w_rs == 5'd0)                              w_rs_val = 32'd0;
        else if (w_wb_we && (r_mem_wb.dest == w_rs))   w_rs_val = w_wb_data;
        if (w_rt == 5'd0)                              w_rt_val = 32'd0;
        else if (w_wb_we && (r_mem_wb.dest == w_rt))   w_rt_val = w_wb_data;
    end

    // Destination register: rd for reg-reg ops, rt for immediate ops and loads.
    always_comb begin
        w_dest = 5'd0;
        case (w_cls)
            CLS_RR_ALU:           w_dest = w_rd;
            CLS_RM_ALU, CLS_LOAD: w_dest = w_rt;
            default:              w_dest = 5'd0;
        endcase
    end

    // ---------------- EX with forwarding ----------------
    // Loads in EX/MEM have no data yet; the load-use stall covers that case.
    assign w_exm_fwd = ((r_ex_mem.cls == CLS_RR_ALU) || (r_ex_mem.cls == CLS_RM_ALU)) &&
                       (r_ex_mem.dest != 5'd0);

    assign w_fwd_a = (w_exm_fwd && (r_ex_mem.dest == r_id_ex.rs)) ? r_ex_mem.alu_out :
                     (w_wb_we && (r_mem_wb.dest == r_id_ex.rs))   ? w_wb_data : r_id_ex.a;
    assign w_fwd_b = (w_exm_fwd && (r_ex_mem.dest == r_id_ex.rt)) ? r_ex_mem.alu_out :
                     (w_wb_we && (r_mem_wb.dest == r_id_ex.rt))   ? w_wb_data : r_id_ex.b;

    assign w_alu_b = (r_id_ex.cls == CLS_RR_ALU) ? w_fwd_b : r_id_ex.imm;
    assign w_taken = (r_id_ex.cls == CLS_BRANCH) &&
                     (r_id_ex.br_on_zero ? (w_fwd_a == 32'd0) : (w_fwd_a != 32'd0));

    mips32_alu u_alu (
        .i_op     (r_id_ex.op),
        .i_a      (w_fwd_a),
        .i_b      (w_alu_b),
        .o_result (w_alu_out)
    );

    // ---------------- hazard control ----------------
    assign w_mem_addr = r_ex_mem.alu_out[c_AW-1:0];
    assign w_squash   = r_ex_mem.taken;
    assign w_stall    = !w_squash && (r_id_ex.cls == CLS_LOAD) && (r_id_ex.dest != 5'd0) &&
                        ((w_uses_rs && (w_rs == r_id_ex.dest)) ||
                         (w_uses_rt && (w_rt == r_id_ex.dest)));
    // A decoded HLT stops fetch until reset, unless it is a squashed wrong-path HLT.
    assign w_fetch_stop = !w_squash &&
                          ((w_cls == CLS_HALT) || (r_id_ex.cls == CLS_HALT) ||
                           (r_ex_mem.cls == CLS_HALT) || (r_mem_wb.cls == CLS_HALT));

    // Next-state for PC and all pipeline registers; squash beats stall beats halt.
    always_comb begin
        w_mem_wb_nx = '{cls: r_ex_mem.cls, dest: r_ex_mem.dest, alu_out: r_ex_mem.alu_out,
                        lmd: Mem[w_mem_addr]};

        w_ex_mem_nx = '{cls: r_id_ex.cls, dest: r_id_ex.dest, alu_out: w_alu_out,
                        b: w_fwd_b, taken: w_taken, target: r_id_ex.npc + r_id_ex.imm};

        w_id_ex_nx  = '{cls: w_cls, op: f_alu_op(w_op), br_on_zero: (w_op == c_OP_BEQZ),
                        rs: w_rs, rt: w_rt, dest: w_dest, a: w_rs_val, b: w_rt_val,
                        imm: {{16{r_if_id.ir[15]}}, r_if_id.ir[15:0]}, npc: r_if_id.npc};

        w_if_id_nx  = '{ir: Mem[PC[c_AW-1:0]], npc: PC + 32'd1};
        w_pc_nx     = PC + 32'd1;

        if (w_squash) begin
            w_ex_mem_nx = c_EX_MEM_NOP;
            w_id_ex_nx  = c_ID_EX_NOP;
            w_if_id_nx  = '{ir: Mem[r_ex_mem.target[c_AW-1:0]], npc: r_ex_mem.target + 32'd1};
            w_pc_nx     = r_ex_mem.target + 32'd1;
        end else if (w_stall) begin
            w_id_ex_nx  = c_ID_EX_NOP;
            w_if_id_nx  = r_if_id;
            w_pc_nx     = PC;
        end else if (w_fetch_stop) begin
            w_if_id_nx  = c_IF_ID_NOP;
            w_pc_nx     = PC;
        end
    end

    // Pipeline and control registers; everything freezes once HALTED is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            PC           <= 32'd0;
            HALTED       <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            r_if_id      <= c_IF_ID_NOP;
            r_id_ex      <= c_ID_EX_NOP;
            r_ex_mem     <= c_EX_MEM_NOP;
            r_mem_wb     <= c_MEM_WB_NOP;
        end else if (!HALTED) begin
            PC           <= w_pc_nx;
            HALTED       <= (r_mem_wb.cls == CLS_HALT);
            TAKEN_BRANCH <= w_squash;
            r_if_id      <= w_if_id_nx;
            r_id_ex      <= w_id_ex_nx;
            r_ex_mem     <= w_ex_mem_nx;
            r_mem_wb     <= w_mem_wb_nx;
        end
    end

    // Register file write-back; a reset edge never commits a write.
    always_ff @(posedge clk) begin
        if (!rst && !HALTED && w_wb_we) begin
            Reg[r_mem_wb.dest] <= w_wb_data;
        end
    end

    // Store commit in MEM; a same-cycle fetch of this word still sees the old value.
    always_ff @(posedge clk) begin
        if (!rst && !HALTED && (r_ex_mem.cls == CLS_STORE)) begin
            Mem[w_mem_addr] <= r_ex_mem.b;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_mips32.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_mips32
// Description : Self-checking bench for pipe_mips32 using directed programs,
//               an expected-state table and hand-written corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_mips32;

    localparam logic [5:0] OP_ADD = 6'b000000, OP_MUL = 6'b000101, OP_LW = 6'b001000,
                           OP_SW = 6'b001001, OP_ADDI = 6'b001010, OP_SUBI = 6'b001011,
                           OP_BNEQZ = 6'b001101, OP_HLT = 6'b111111;

    typedef struct {
        int          prog;
        bit          is_mem;
        int          idx;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic halted;

    int          n_pass  = 0;
    int          n_total = 0;
    int          taken_cnt;
    int          cyc;
    int          diffs;
    logic [31:0] prog_q [$];
    exp_t        tbl [$];
    logic [31:0] snap_reg [0:31];
    logic [31:0] snap_mem [0:15];
    logic [31:0] snap_pc;

    pipe_mips32 #(.MEM_WORDS(1024)) dut (
        .clk    (clk),
        .rst    (rst),
        .halted (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [5:0] op, input int rd, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
    endtask

    // Hold reset, clear memory, load prog_q at address 0 and preload Reg[k]=k.
    task automatic start_prog();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'd0;
        for (int i = 0; i < prog_q.size(); i++) dut.Mem[i] = prog_q[i];
        for (int k = 0; k < 32; k++) dut.Reg[k] = 32'(k);
    endtask

    task automatic run_to_halt(input int budget, output int cycles);
        cycles    = 0;
        taken_cnt = 0;
        while (!halted && cycles < budget) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
            if (dut.TAKEN_BRANCH) taken_cnt++;
        end
    endtask

    task automatic verify_prog(input int id);
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].prog == id) begin
                if (tbl[i].is_mem) check(tbl[i].name, dut.Mem[tbl[i].idx], tbl[i].exp);
                else               check(tbl[i].name, dut.Reg[tbl[i].idx], tbl[i].exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        // Expected architectural state after each program halts.
        tbl.push_back('{1, 1'b0, 1,  32'd10,   "p1_r1"});
        tbl.push_back('{1, 1'b0, 2,  32'd20,   "p1_r2"});
        tbl.push_back('{1, 1'b0, 3,  32'd25,   "p1_r3"});
        tbl.push_back('{1, 1'b0, 4,  32'd30,   "p1_r4"});
        tbl.push_back('{1, 1'b0, 5,  32'd55,   "p1_r5"});
        tbl.push_back('{1, 1'b0, 6,  32'd6,    "p1_r6"});
        tbl.push_back('{1, 1'b0, 15, 32'd7,    "p1_r15"});
        tbl.push_back('{2, 1'b0, 1,  32'd5,    "p2_r1"});
        tbl.push_back('{2, 1'b0, 2,  32'd10,   "p2_r2"});
        tbl.push_back('{2, 1'b0, 3,  32'd15,   "p2_r3"});
        tbl.push_back('{3, 1'b1, 121, 32'd130, "p3_mem121"});
        tbl.push_back('{3, 1'b0, 2,  32'd130,  "p3_r2"});
        tbl.push_back('{3, 1'b1, 120, 32'd85,  "p3_mem120"});
        tbl.push_back('{4, 1'b1, 198, 32'd5040, "p4_mem198"});
        tbl.push_back('{4, 1'b0, 2,  32'd5040, "p4_r2"});
        tbl.push_back('{4, 1'b0, 3,  32'd0,    "p4_r3"});
        tbl.push_back('{4, 1'b0, 20, 32'd21,   "p4_r20_once"});
        tbl.push_back('{4, 1'b0, 21, 32'd22,   "p4_r21_once"});
        tbl.push_back('{5, 1'b0, 1,  32'd3,    "p5_r1"});
        tbl.push_back('{5, 1'b0, 9,  32'd9,    "p5_r9_not_run"});
        tbl.push_back('{6, 1'b0, 13, 32'd15,   "p6_r13"});
        tbl.push_back('{6, 1'b0, 7,  32'd70,   "p6_r7"});
        tbl.push_back('{6, 1'b0, 8,  32'd80,   "p6_r8"});

        // Program 1: independent ALU ops and a late dependency chain.
        prog_q.delete();
        prog_q = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                   32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
        start_prog();
        check("rst_pc", dut.PC, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
        rst = 1'b0;
        run_to_halt(40, cyc);
        check("p1_halted", {31'd0, halted}, 32'd1);
        check("p1_cycles", 32'(cyc), 32'd13);
        verify_prog(1);

        // Program 2: back-to-back dependencies through forwarding.
        prog_q.delete();
        prog_q.push_back(enc_i(OP_ADDI, 1, 0, 5));
        prog_q.push_back(enc_r(OP_ADD, 2, 1, 1));
        prog_q.push_back(enc_r(OP_ADD, 3, 2, 1));
        prog_q.push_back({OP_HLT, 26'd0});
        start_prog();
        rst = 1'b0;
        run_to_halt(40, cyc);
        check("p2_halted", {31'd0, halted}, 32'd1);
        check("p2_cycles", 32'(cyc), 32'd8);
        verify_prog(2);

        // Program 3: load-use stall then store.
        prog_q.delete();
        prog_q.push_back(enc_i(OP_ADDI, 1, 0, 120));
        prog_q.push_back(enc_i(OP_LW, 2, 1, 0));
        prog_q.push_back(enc_i(OP_ADDI, 2, 2, 45));
        prog_q.push_back(enc_i(OP_SW, 2, 1, 1));
        prog_q.push_back({OP_HLT, 26'd0});
        start_prog();
        dut.Mem[120] = 32'd85;
        rst = 1'b0;
        run_to_halt(40, cyc);
        check("p3_halted", {31'd0, halted}, 32'd1);
        check("p3_cycles_stall", 32'(cyc), 32'd10);
        verify_prog(3);

        // Program 4: factorial loop; R20/R21 incrementers sit in the branch shadow.
        prog_q.delete();
        prog_q.push_back(enc_i(OP_ADDI, 10, 0, 200));
        prog_q.push_back(enc_i(OP_LW, 3, 10, 0));
        prog_q.push_back(enc_i(OP_ADDI, 2, 0, 1));
        prog_q.push_back(enc_r(OP_MUL, 2, 2, 3));
        prog_q.push_back(enc_i(OP_SUBI, 3, 3, 1));
        prog_q.push_back(enc_i(OP_BNEQZ, 0, 3, -3));
        prog_q.push_back(enc_i(OP_ADDI, 20, 20, 1));
        prog_q.push_back(enc_i(OP_ADDI, 21, 21, 1));
        prog_q.push_back(enc_i(OP_SW, 2, 10, -2));
        prog_q.push_back({OP_HLT, 26'd0});
        start_prog();
        dut.Mem[200] = 32'd7;
        rst = 1'b0;
        run_to_halt(200, cyc);
        check("p4_halted", {31'd0, halted}, 32'd1);
        check("p4_cycles", 32'(cyc), 32'd44);
        check("p4_taken_cnt", 32'(taken_cnt), 32'd6);
        verify_prog(4);

        // Program 5: halt freeze; the ADDI after HLT must never execute.
        prog_q.delete();
        prog_q.push_back(enc_i(OP_ADDI, 1, 0, 3));
        prog_q.push_back({OP_HLT, 26'd0});
        prog_q.push_back(enc_i(OP_ADDI, 9, 0, 1));
        start_prog();
        rst = 1'b0;
        run_to_halt(40, cyc);
        check("p5_halted", {31'd0, halted}, 32'd1);
        check("p5_cycles", 32'(cyc), 32'd6);
        check("p5_pc", dut.PC, 32'd2);
        snap_pc = dut.PC;
        for (int k = 0; k < 32; k++) snap_reg[k] = dut.Reg[k];
        for (int k = 0; k < 16; k++) snap_mem[k] = dut.Mem[k];
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("p5_pc_frozen", dut.PC, snap_pc);
        diffs = 0;
        for (int k = 0; k < 32; k++) if (dut.Reg[k] !== snap_reg[k]) diffs++;
        for (int k = 0; k < 16; k++) if (dut.Mem[k] !== snap_mem[k]) diffs++;
        check("p5_state_frozen", 32'(diffs), 32'd0);
        check("p5_still_halted", {31'd0, halted}, 32'd1);
        verify_prog(5);

        // Program 6: reset pulse mid-run discards in-flight work, keeps Reg.
        prog_q.delete();
        prog_q.push_back(enc_i(OP_ADDI, 13, 13, 1));
        prog_q.push_back(enc_i(OP_ADDI, 7, 0, 70));
        prog_q.push_back(enc_i(OP_ADDI, 8, 0, 80));
        prog_q.push_back({OP_HLT, 26'd0});
        start_prog();
        rst = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("p6_rst_pc", dut.PC, 32'd0);
        check("p6_rst_halted", {31'd0, halted}, 32'd0);
        check("p6_rst_r13_kept", dut.Reg[13], 32'd14);
        check("p6_rst_r7_kept", dut.Reg[7], 32'd70);
        check("p6_rst_r8_no_write", dut.Reg[8], 32'd8);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("p6_first_fetch_pc", dut.PC, 32'd1);
        run_to_halt(40, cyc);
        check("p6_halted", {31'd0, halted}, 32'd1);
        verify_prog(6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
